// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register map, STATUS/CTRL bit positions and FSM encoding for uart_tx_dev.
package uart_tx_pkg;
   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_STAT = 2'd1;
   localparam logic [1:0] A_CTRL = 2'd2;
   localparam logic [1:0] A_DIV  = 2'd3;
   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 4;
   localparam int CT_EN  = 0;
   localparam int CT_IE  = 1;
   localparam int CT_ODD = 2;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO of depth 2**FIFO_AW with combinational head output.
module tx_fifo #(
   parameter int FIFO_AW = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic             full,
   output logic             empty,
   output logic [FIFO_AW:0] count
);
   logic [7:0] mem_q [2**FIFO_AW];
   logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [FIFO_AW:0] cnt_q, cnt_d;
   always_comb begin
      wr_d  = wr_q + FIFO_AW'(push);
      rd_d  = rd_q + FIFO_AW'(pop);
      cnt_d = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
   end
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   assign dout  = mem_q[rd_q];
   assign full  = cnt_q == (FIFO_AW+1)'(2**FIFO_AW);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with TX FIFO and drain IRQ.
// Define UART_TX_PARITY_EN to add a parity bit (CTRL.ODD selects odd parity).
module uart_tx_dev
   import uart_tx_pkg::*;
#(
   parameter int          FIFO_AW = 2,
   parameter logic [15:0] DIV_RST = 16'd16
) (
   input  logic        clk,
   input  logic        RST_I,
   input  logic [1:0]  ADD_I,
   input  logic        WE_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        IRQ,
   output logic        TXD
);
`ifdef UART_TX_PARITY_EN
   localparam state_e     AFTER_DATA = PARITY;
   localparam logic [2:0] CTRL_MASK  = 3'b111;
`else
   localparam state_e     AFTER_DATA = STOP;
   localparam logic [2:0] CTRL_MASK  = 3'b011;
`endif
   state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_q, bit_d;
   logic [15:0] cnt_q, cnt_d, div_q, div_d, reload;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        par_q, par_d, txd_q, txd_d, irq_q, irq_d, ovf_q, ovf_d;
   logic        push_req, push, pop, tick;
   logic [7:0]  f_dout;
   logic        f_full, f_empty;
   logic [FIFO_AW:0] f_count;
   logic [31:0] stat;
   logic        unused_ok;
   assign unused_ok = ^DAT_I[31:16];
   assign push_req = WE_I && ADD_I == A_DATA;
   assign pop      = state_q == IDLE && ctrl_q[CT_EN] && !f_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
   assign push     = push_req && (!f_full || pop);
   assign tick     = cnt_q == '0;
   assign reload   = (div_q == '0) ? 16'd0 : div_q - 16'd1;
   tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clk(clk), .rst(RST_I), .push(push), .pop(pop), .din(DAT_I[7:0]),
      .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
   );
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      par_d   = par_q;
      case (state_q)
         IDLE: if (pop) begin
            state_d = START;
            shift_d = f_dout;
            par_d   = ^f_dout ^ ctrl_q[CT_ODD];
         end
         START:  state_d = tick ? DATA : START;
         DATA: if (tick) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
         end
         PARITY: state_d = tick ? STOP : PARITY;
         STOP:   state_d = tick ? IDLE : STOP;
         default: state_d = IDLE;
      endcase
      // The divisor is sampled only at bit boundaries, so DIVISOR writes never stretch a live bit.
      cnt_d  = (state_q == IDLE || tick) ? reload : cnt_q - 16'd1;
      txd_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
               (state_d == PARITY) ? par_d : 1'b1;
      irq_d  = ctrl_q[CT_IE] && f_empty && state_q == IDLE;
      ovf_d  = (WE_I && ADD_I == A_STAT) ? 1'b0 : (push_req && f_full && !pop) ? 1'b1 : ovf_q;
      ctrl_d = (WE_I && ADD_I == A_CTRL) ? DAT_I[2:0] & CTRL_MASK : ctrl_q;
      div_d  = (WE_I && ADD_I == A_DIV) ? DAT_I[15:0] : div_q;
   end
   always_ff @(posedge clk or posedge RST_I)
      if (RST_I) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         irq_q   <= 1'b0;
         ovf_q   <= 1'b0;
         ctrl_q  <= '0;
         div_q   <= DIV_RST;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         irq_q   <= irq_d;
         ovf_q   <= ovf_d;
         ctrl_q  <= ctrl_d;
         div_q   <= div_d;
      end
   always_comb begin
      stat = '0;
      stat[ST_BUSY]   = state_q != IDLE;
      stat[ST_FULL]   = f_full;
      stat[ST_EMPTY]  = f_empty;
      stat[ST_OVF]    = ovf_q;
      stat[ST_CNT+:3] = 3'(f_count);
   end
   assign DAT_O = (ADD_I == A_STAT) ? stat : (ADD_I == A_CTRL) ? {29'd0, ctrl_q} :
                  (ADD_I == A_DIV) ? {16'd0, div_q} : 32'd0;
   assign IRQ = irq_q;
   assign TXD = txd_q;
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed self-checking bench for uart_tx_dev (both UART_TX_PARITY_EN builds).
module tb_uart_tx_dev;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        RST_I = 1'b1;
   logic [1:0]  ADD_I = 2'd0;
   logic        WE_I = 1'b0;
   logic [31:0] DAT_I = 32'd0;
   logic [31:0] DAT_O;
   logic        IRQ, TXD;
   int tests = 0;
   int fails = 0;
   int n;
   int zeros;
   uart_tx_dev #(.FIFO_AW(2), .DIV_RST(16'd16)) dut (
      .clk(clk), .RST_I(RST_I), .ADD_I(ADD_I), .WE_I(WE_I),
      .DAT_I(DAT_I), .DAT_O(DAT_O), .IRQ(IRQ), .TXD(TXD)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      ADD_I = a;
      DAT_I = d;
      WE_I  = 1'b1;
      @(negedge clk);
      WE_I  = 1'b0;
   endtask
   task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
      @(negedge clk);
      ADD_I = a;
      #1;
      check(tag, DAT_O, e);
   endtask
   // Waits (bounded) for the start bit, then checks every cycle of one frame.
   task automatic frame(input logic [7:0] b, input int div, input logic odd, output int waited);
      int nb;
      logic [10:0] bits;
      nb   = PAR ? 11 : 10;
      bits = PAR ? {1'b1, ^b ^ odd, b, 1'b0} : {2'b11, b, 1'b0};
      ADD_I = 2'd1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (TXD !== 1'b0 && waited < 300);
      for (int i = 0; i < nb * div; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("txd_%02h_%0d", b, i), TXD, bits[i / div]);
         check("busy", DAT_O[0], 1);
         check("irq_in_frame", IRQ, 0);
      end
   endtask
   initial begin
      repeat (3) @(negedge clk);
      RST_I = 1'b0;
      rd(2'd1, 32'h4, "rst_status");
      rd(2'd2, 32'h0, "rst_ctrl");
      rd(2'd3, 32'd16, "rst_div");
      rd(2'd0, 32'h0, "rst_data");
      check("rst_txd", TXD, 1);
      check("rst_irq", IRQ, 0);
      wr(2'd3, 32'd4);
      wr(2'd2, 32'd1);
      wr(2'd0, 32'h55);
      frame(8'h55, 4, 1'b0, n);
      check("latency_55", n, 1);
      wr(2'd2, 32'd0);
      for (int k = 0; k < 4; k++) wr(2'd0, 32'h11 + k);
      rd(2'd1, 32'h42, "full_status");
      wr(2'd0, 32'h15);
      rd(2'd1, 32'h4a, "ovf_status");
      wr(2'd1, 32'd0);
      rd(2'd1, 32'h42, "ovf_clear");
      wr(2'd2, 32'd1);
      frame(8'h11, 4, 1'b0, n);
      check("latency_11", n, 1);
      for (int k = 1; k < 4; k++) begin
         frame(8'h11 + 8'(k), 4, 1'b0, n);
         check("gap", n, 2);
      end
      zeros = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (TXD === 1'b0) zeros++;
      end
      check("no_0x15", zeros, 0);
      rd(2'd1, 32'h4, "drained_status");
      wr(2'd3, 32'd2);
      wr(2'd2, 32'd3);
      wr(2'd0, 32'ha5);
      frame(8'ha5, 2, 1'b0, n);
      check("latency_a5", n, 1);
      @(negedge clk);
      check("irq_idle_cycle", IRQ, 0);
      @(negedge clk);
      check("irq_rise", IRQ, 1);
      wr(2'd0, 32'h00);
      check("irq_push_cycle", IRQ, 1);
      frame(8'h00, 2, 1'b0, n);
      check("latency_00", n, 1);
      wr(2'd2, 32'd2);
      wr(2'd0, 32'hf0);
      wr(2'd0, 32'h0f);
      wr(2'd2, 32'd3);
      ADD_I = 2'd1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (TXD !== 1'b0 && n < 300);
      check("latency_f0", n, 1);
      repeat (8) @(negedge clk);
      check("f0_bit3", TXD, 0);
      check("f0_status", DAT_O, 32'h11);
      RST_I = 1'b1;
      #1;
      check("async_txd", TXD, 1);
      check("async_irq", IRQ, 0);
      check("async_status", DAT_O, 32'h4);
      repeat (2) @(negedge clk);
      RST_I = 1'b0;
      rd(2'd2, 32'h0, "rst2_ctrl");
      rd(2'd3, 32'd16, "rst2_div");
      zeros = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (TXD === 1'b0) zeros++;
      end
      check("no_frame_after_rst", zeros, 0);
      rd(2'd1, 32'h4, "rst2_status");
      wr(2'd3, 32'd1);
      wr(2'd2, 32'd5);
      rd(2'd2, PAR ? 32'd5 : 32'd1, "ctrl_odd");
      wr(2'd0, 32'h03);
      frame(8'h03, 1, 1'b1, n);
      check("latency_03_odd", n, 1);
      wr(2'd2, 32'd1);
      wr(2'd0, 32'h03);
      frame(8'h03, 1, 1'b0, n);
      check("latency_03_even", n, 1);
      wr(2'd3, 32'd0);
      rd(2'd3, 32'd0, "div_zero");
      wr(2'd0, 32'ha6);
      frame(8'ha6, 1, 1'b0, n);
      check("latency_div0", n, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
